// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache, one 32-bit word per line.
// Hits respond in one cycle; misses refill through the memory controller port.
module inst_cache #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 30 - INDEX_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        pc_valid,
  input  logic [31:0] pc,
  output logic        inst_ready,
  output logic [31:0] inst,
  output logic        fetch_enable,
  output logic [31:0] inst_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int LINES = 1 << INDEX_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MISS = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  logic                   discard;
  logic [LINES-1:0]       valid;
  logic [TAG_WIDTH-1:0]   tags [LINES];
  logic [31:0]            data [LINES];
  logic [INDEX_WIDTH-1:0] miss_idx;
  logic [TAG_WIDTH-1:0]   miss_tag;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   tag;
  logic                   hit;
  logic                   fill;
  logic                   unused;

  assign idx    = pc[INDEX_WIDTH+1:2];
  assign tag    = pc[31:INDEX_WIDTH+2];
  assign hit    = valid[idx] && (tags[idx] == tag);
  assign fill   = !rst && rdy && (state == MISS) && mem_valid;
  assign unused = ^pc[1:0];

  // Tag/data storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[miss_idx] <= miss_tag;
      data[miss_idx] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid        <= '0;
      state        <= IDLE;
      discard      <= 1'b0;
      inst_ready   <= 1'b0;
      inst         <= '0;
      fetch_enable <= 1'b0;
      inst_addr    <= '0;
      miss_idx     <= '0;
      miss_tag     <= '0;
    end else if (rdy) begin
      unique case (state)
        IDLE: begin
          inst_ready <= 1'b0;
          if (clear) begin
            state <= IDLE;
          end else if (pc_valid) begin
            if (hit) begin
              inst       <= data[idx];
              inst_ready <= 1'b1;
              state      <= DONE;
            end else begin
              fetch_enable <= 1'b1;
              inst_addr    <= {pc[31:2], 2'b00};
              miss_idx     <= idx;
              miss_tag     <= tag;
              discard      <= 1'b0;
              state        <= MISS;
            end
          end
        end
        MISS: begin
          if (clear) discard <= 1'b1;
          if (mem_valid) begin
            valid[miss_idx] <= 1'b1;
            fetch_enable    <= 1'b0;
            state           <= DONE;
            // Flushed requests still fill the line, but nobody hears about it.
            if (!discard && !clear) begin
              inst       <= mem_data;
              inst_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          inst_ready <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: per-cycle vector table plus
// hand-written stall and bounded-wait sequences.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, pc_valid, mem_valid;
  logic [31:0] pc, mem_data;
  logic        inst_ready, fetch_enable;
  logic [31:0] inst, inst_addr;

  int n_assert = 0;
  int n_fail   = 0;

  inst_cache #(.INDEX_WIDTH(6)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .clear(clear),
    .pc_valid(pc_valid),
    .pc(pc),
    .inst_ready(inst_ready),
    .inst(inst),
    .fetch_enable(fetch_enable),
    .inst_addr(inst_addr),
    .mem_valid(mem_valid),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, clr, pv;
    logic [31:0] pc;
    logic        mv;
    logic [31:0] md;
    logic        er;
    logic [31:0] ei;
    logic        ef;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rs, input logic ry, input logic cl, input logic pv,
    input logic [31:0] p, input logic mv, input logic [31:0] md,
    input logic er, input logic [31:0] ei,
    input logic ef, input logic [31:0] ea);
    vec_t v;
    v.rst = rs; v.rdy = ry; v.clr = cl; v.pv = pv;
    v.pc = p; v.mv = mv; v.md = md;
    v.er = er; v.ei = ei; v.ef = ef; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rs, input logic ry, input logic cl,
                       input logic pv, input logic [31:0] p,
                       input logic mv, input logic [31:0] md);
    rst = rs; rdy = ry; clear = cl; pc_valid = pv;
    pc = p; mem_valid = mv; mem_data = md;
  endtask

  initial begin
    int waited;
    drive(1, 1, 0, 0, 0, 0, 0);
    //            rst rdy clr pv pc         mv md           er ei           ef ea
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0,   0, 32'h0,        0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0,   0, 32'h0,        0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0,   1, 32'h13,       1, 32'h13,       0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0,   0, 32'h0,        1, 32'h13,       0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h100, 0, 32'h0,        0, 32'h0,        1, 32'h100));
    tbl.push_back(mk(0, 1, 0, 1, 32'h100, 1, 32'hFF010113, 1, 32'hFF010113, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h100, 0, 32'h0,        1, 32'hFF010113, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h2,   0, 32'h0,        0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h2,   1, 32'h13,       1, 32'h13,       0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h8,   0, 32'h0,        0, 32'h0,        1, 32'h8));
    tbl.push_back(mk(0, 1, 1, 1, 32'h8,   0, 32'h0,        0, 32'h0,        1, 32'h8));
    tbl.push_back(mk(0, 1, 0, 1, 32'h8,   0, 32'h0,        0, 32'h0,        1, 32'h8));
    tbl.push_back(mk(0, 1, 0, 1, 32'h8,   1, 32'h00A00093, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h8,   0, 32'h0,        1, 32'h00A00093, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'hC,   0, 32'h0,        0, 32'h0,        1, 32'hC));
    tbl.push_back(mk(0, 1, 1, 1, 32'hC,   1, 32'h11111111, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'hC,   0, 32'h0,        1, 32'h11111111, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 1, 32'h10,  0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   1, 32'hDEAD,     0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h14,  0, 32'h0,        0, 32'h0,        1, 32'h14));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   1, 32'h123,      0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0,   0, 32'h0,        0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0,   1, 32'h13,       1, 32'h13,       0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h0,   0, 32'h0,        1, 32'h13,       0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h13,       0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,        0, 32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.rdy, v.clr, v.pv, v.pc, v.mv, v.md);
      tick();
      chk($sformatf("row%0d inst_ready", i), {31'b0, inst_ready}, {31'b0, v.er});
      chk($sformatf("row%0d fetch_enable", i), {31'b0, fetch_enable}, {31'b0, v.ef});
      if (v.er || v.rst) chk($sformatf("row%0d inst", i), inst, v.ei);
      if (v.ef || v.rst) chk($sformatf("row%0d inst_addr", i), inst_addr, v.ea);
    end

    // Miss held off by rdy=0 while the controller keeps mem_valid high.
    drive(0, 1, 0, 1, 32'h20, 0, 0);
    tick();
    chk("stall miss fe", {31'b0, fetch_enable}, 32'd1);
    chk("stall miss addr", inst_addr, 32'h20);
    drive(0, 0, 0, 1, 32'h20, 1, 32'hCAFEBABE);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d ready", k), {31'b0, inst_ready}, 32'd0);
      chk($sformatf("stall%0d fe", k), {31'b0, fetch_enable}, 32'd1);
    end
    rdy = 1'b1;
    tick();
    chk("stall resume ready", {31'b0, inst_ready}, 32'd1);
    chk("stall resume inst", inst, 32'hCAFEBABE);
    chk("stall resume fe", {31'b0, fetch_enable}, 32'd0);
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    chk("stall bubble ready", {31'b0, inst_ready}, 32'd0);

    // Bounded wait for a hit on the line just filled.
    drive(0, 1, 0, 1, 32'h20, 0, 0);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!inst_ready && waited < 10);
    chk("hit wait cycles", waited, 32'd1);
    chk("hit wait inst", inst, 32'hCAFEBABE);
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    chk("hit wait bubble", {31'b0, inst_ready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
